// File: rtl/ws2812b_frame_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ws2812b_frame_controller                                                 |
// | Frame sequencer: counts bits/pixels, captures the addressed pixel and    |
// | drives downstream forwarding for the impostor WS2812b peripheral.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ws2812b_frame_controller #(
  parameter int PIXEL_BITS = 24,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idle,
  input  logic                  bit_valid,
  input  logic                  bit_value,
  input  logic [IDX_W-1:0]      target_index,
  input  logic                  capture_en,
  input  logic                  clear_valid,
  output logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  forward_en,
  output logic                  frame_done,
  output logic [IDX_W-1:0]      frame_pixels,
  output logic                  partial_err,
  output logic                  overflow
);

  localparam int                CNT_W    = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(PIXEL_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    READY   = 2'd1,
    RECEIVE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      pixel_cnt_q, pixel_cnt_d;
  logic [PIXEL_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      target_q, target_d;
  logic                  cap_q, cap_d;
  logic                  ovf_run_q, ovf_run_d;
  logic [PIXEL_BITS-1:0] pixel_data_q, pixel_data_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic                  forward_en_q, forward_en_d;
  logic                  frame_done_q, frame_done_d;
  logic [IDX_W-1:0]      frame_pixels_q, frame_pixels_d;
  logic                  partial_err_q, partial_err_d;
  logic                  overflow_q, overflow_d;

  logic                  take_bit;
  logic [PIXEL_BITS-1:0] next_word;
  logic [IDX_W-1:0]      tgt_sel;
  logic                  cap_sel;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    pixel_cnt_d    = pixel_cnt_q;
    shift_d        = shift_q;
    target_d       = target_q;
    cap_d          = cap_q;
    ovf_run_d      = ovf_run_q;
    pixel_data_d   = pixel_data_q;
    pixel_valid_d  = pixel_valid_q;
    forward_en_d   = forward_en_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    partial_err_d  = partial_err_q;
    overflow_d     = overflow_q;

    // Idle always wins over a coincident bit strobe.
    take_bit  = bit_valid && !idle && ((state_q == READY) || (state_q == RECEIVE));
    next_word = {shift_q[PIXEL_BITS-2:0], bit_value};
    tgt_sel   = (state_q == READY) ? target_index : target_q;
    cap_sel   = (state_q == READY) ? capture_en   : cap_q;

    case (state_q)
      SYNC: begin
        if (idle) state_d = READY;
      end
      READY: begin
        if (take_bit) begin
          state_d  = RECEIVE;
          target_d = target_index;
          cap_d    = capture_en;
        end
      end
      RECEIVE: begin
        if (idle) begin
          state_d        = READY;
          frame_done_d   = 1'b1;
          frame_pixels_d = pixel_cnt_q;
          partial_err_d  = (bit_cnt_q != '0);
          overflow_d     = ovf_run_q;
          forward_en_d   = 1'b0;
          bit_cnt_d      = '0;
          pixel_cnt_d    = '0;
          ovf_run_d      = 1'b0;
        end
      end
      default: state_d = SYNC;
    endcase

    if (clear_valid) pixel_valid_d = 1'b0;

    if (take_bit) begin
      shift_d = next_word;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        // A saturated counter means this pixel has no valid index.
        if (pixel_cnt_q == IDX_MAX) begin
          ovf_run_d = 1'b1;
        end else begin
          pixel_cnt_d = pixel_cnt_q + IDX_W'(1);
          if (cap_sel && (pixel_cnt_q == tgt_sel)) begin
            pixel_data_d  = next_word;
            pixel_valid_d = 1'b1;
            forward_en_d  = 1'b1;
          end
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SYNC;
      bit_cnt_q      <= '0;
      pixel_cnt_q    <= '0;
      shift_q        <= '0;
      target_q       <= '0;
      cap_q          <= 1'b0;
      ovf_run_q      <= 1'b0;
      pixel_data_q   <= '0;
      pixel_valid_q  <= 1'b0;
      forward_en_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      partial_err_q  <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      pixel_cnt_q    <= pixel_cnt_d;
      shift_q        <= shift_d;
      target_q       <= target_d;
      cap_q          <= cap_d;
      ovf_run_q      <= ovf_run_d;
      pixel_data_q   <= pixel_data_d;
      pixel_valid_q  <= pixel_valid_d;
      forward_en_q   <= forward_en_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      partial_err_q  <= partial_err_d;
      overflow_q     <= overflow_d;
    end
  end

  assign pixel_data   = pixel_data_q;
  assign pixel_valid  = pixel_valid_q;
  assign forward_en   = forward_en_q;
  assign frame_done   = frame_done_q;
  assign frame_pixels = frame_pixels_q;
  assign partial_err  = partial_err_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_frame_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ws2812b_frame_controller                                              |
// | Scoreboard bench: default instance plus a 4-bit index instance.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ws2812b_frame_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idle = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_value = 1'b0;
  logic [7:0]  target_index = 8'd0;
  logic        capture_en = 1'b0;
  logic        clear_valid = 1'b0;

  logic [23:0] pixel_data;
  logic        pixel_valid, forward_en, frame_done, partial_err, overflow;
  logic [7:0]  frame_pixels;

  logic [23:0] pixel_data4;
  logic        pixel_valid4, forward_en4, frame_done4, partial_err4, overflow4;
  logic [3:0]  frame_pixels4;

  ws2812b_frame_controller #(.PIXEL_BITS(24), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .idle(idle), .bit_valid(bit_valid), .bit_value(bit_value),
    .target_index(target_index), .capture_en(capture_en), .clear_valid(clear_valid),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .forward_en(forward_en),
    .frame_done(frame_done), .frame_pixels(frame_pixels), .partial_err(partial_err),
    .overflow(overflow)
  );

  ws2812b_frame_controller #(.PIXEL_BITS(24), .IDX_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .idle(idle), .bit_valid(bit_valid), .bit_value(bit_value),
    .target_index(target_index[3:0]), .capture_en(capture_en), .clear_valid(clear_valid),
    .pixel_data(pixel_data4), .pixel_valid(pixel_valid4), .forward_en(forward_en4),
    .frame_done(frame_done4), .frame_pixels(frame_pixels4), .partial_err(partial_err4),
    .overflow(overflow4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pixels;
    logic        partial;
    logic        ovf;
    logic [23:0] pd;
    logic        pv;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb4[$];
  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_pd = 24'd0;
  logic        exp_pv = 1'b0;
  logic [23:0] fpix [0:31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-end monitor: pops the expected record on every frame_done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && frame_done) begin
      if (sb.size() == 0) chk("unexpected_frame_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("frame_pixels", 32'(frame_pixels), 32'(e.pixels));
        chk("partial_err", 32'(partial_err), 32'(e.partial));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("pixel_data", 32'(pixel_data), 32'(e.pd));
        chk("pixel_valid", 32'(pixel_valid), 32'(e.pv));
      end
    end
    if (rst_n && frame_done4) begin
      if (sb4.size() == 0) chk("unexpected_frame_done4", 32'd1, 32'd0);
      else begin
        e = sb4.pop_front();
        chk("frame_pixels4", 32'(frame_pixels4), 32'(e.pixels));
        chk("partial_err4", 32'(partial_err4), 32'(e.partial));
        chk("overflow4", 32'(overflow4), 32'(e.ovf));
      end
    end
  end

  task automatic raw_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_value = w[23 - (i % 24)];
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_frame(input int npix, input int nextra, input int tgt, input int mid_tgt,
                            input bit cap, input bit clr_at_cap);
    int          total;
    bit          hit;
    exp_t        e;
    logic [23:0] w;
    total = npix * 24 + nextra;
    hit   = cap && (tgt < npix);
    target_index = 8'(tgt);
    capture_en   = cap;
    idle         = 1'b0;
    for (int i = 0; i <= total; i++) begin
      @(negedge clk);
      chk("forward_en", 32'(forward_en), 32'(hit && ((i / 24) > tgt)));
      clear_valid = 1'b0;
      if (i == 1) target_index = 8'(mid_tgt);
      if (i < total) begin
        bit_valid = 1'b1;
        if (i < npix * 24) begin
          w = fpix[i / 24];
          bit_value = w[23 - (i % 24)];
        end else begin
          bit_value = i[0];
        end
        if (clr_at_cap && hit && (i == tgt * 24 + 23)) clear_valid = 1'b1;
      end else begin
        bit_valid = 1'b0;
      end
    end
    if (hit) begin
      exp_pd = fpix[tgt];
      exp_pv = 1'b1;
    end
    e.pixels  = 8'(npix);
    e.partial = (nextra != 0);
    e.ovf     = 1'b0;
    e.pd      = exp_pd;
    e.pv      = exp_pv;
    sb.push_back(e);
    e.pixels  = (npix > 15) ? 8'd15 : 8'(npix);
    e.ovf     = (npix > 15);
    sb4.push_back(e);
    idle = 1'b1;
    for (int k = 0; k < 10 && (sb.size() != 0 || sb4.size() != 0); k++) @(negedge clk);
    chk("frame_done_seen", 32'(sb.size() + sb4.size()), 32'd0);
    chk("forward_en_after_end", 32'(forward_en), 32'd0);
    @(negedge clk);
    chk("frame_done_single", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    idle = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pixel_data"}, 32'(pixel_data), 32'd0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    chk({tag, "_forward_en"}, 32'(forward_en), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_pixels"}, 32'(frame_pixels), 32'd0);
    chk({tag, "_partial_err"}, 32'(partial_err), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) fpix[i] = 24'(32'h00010203 * (i + 1) ^ 32'h005A3C00);

    // Reset, then a frame already in progress must be ignored.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    target_index = 8'd0;
    capture_en   = 1'b1;
    raw_bits(24'hFFFFFF, 24);
    chk("sync_no_capture", 32'(pixel_valid), 32'd0);
    chk("sync_no_forward", 32'(forward_en), 32'd0);
    idle = 1'b1;
    repeat (4) @(negedge clk);
    chk("sync_frame_pixels", 32'(frame_pixels), 32'd0);
    idle = 1'b0;
    @(negedge clk);

    // Capture of pixel 0 in a 3-pixel frame.
    fpix[0] = 24'h123456; fpix[1] = 24'hABCDEF; fpix[2] = 24'h0F0F0F;
    send_frame(3, 0, 0, 0, 1'b1, 1'b0);

    // Target beyond the frame length: nothing captured.
    fpix[0] = 24'h777777; fpix[1] = 24'h888888;
    send_frame(2, 0, 2, 2, 1'b1, 1'b0);

    // Frame ending mid-pixel.
    fpix[0] = 24'h999999;
    send_frame(1, 10, 1, 1, 1'b1, 1'b0);

    // Standalone clear leaves the data alone.
    @(negedge clk);
    clear_valid = 1'b1;
    @(negedge clk);
    clear_valid = 1'b0;
    exp_pv = 1'b0;
    chk("clear_pixel_valid", 32'(pixel_valid), 32'(exp_pv));
    chk("clear_pixel_data", 32'(pixel_data), 32'(exp_pd));

    // Clear coincident with capture: set wins; also clears partial_err.
    fpix[0] = 24'hA5A5A5; fpix[1] = 24'h5A5A5A;
    send_frame(2, 0, 1, 1, 1'b1, 1'b1);

    // Target change mid-frame is ignored.
    fpix[0] = 24'h111111; fpix[1] = 24'h222222; fpix[2] = 24'h333333;
    send_frame(3, 0, 0, 2, 1'b1, 1'b0);

    // 17 pixels: saturates the 4-bit instance.
    for (int i = 0; i < 17; i++) fpix[i] = 24'(32'h00102030 + i);
    send_frame(17, 0, 0, 0, 1'b0, 1'b0);
    send_frame(1, 0, 0, 0, 1'b0, 1'b0);

    // Reset pulse mid-frame after a capture.
    target_index = 8'd0;
    capture_en   = 1'b1;
    raw_bits(24'hDEAD01, 30);
    chk("mid_forward_before_reset", 32'(forward_en), 32'd1);
    chk("mid_data_before_reset", 32'(pixel_data), 32'hDEAD01);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_pd = 24'd0;
    exp_pv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    raw_bits(24'h00FF00, 24);
    chk("post_reset_ignored", 32'(pixel_valid), 32'd0);
    idle = 1'b1;
    repeat (4) @(negedge clk);
    idle = 1'b0;
    fpix[0] = 24'hC0FFEE;
    send_frame(1, 0, 0, 0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size() + sb4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
